bcd_digit_extractor: RTL and testbench

- Sequential binary-to-BCD converter (shift-add-3 / double-dabble) sitting directly upstream of the VGA digit renderer.
- Takes the processor/RAM result byte and produces per-digit BCD nibbles plus a leading-zero-suppressed digit count.
- Replaces in-display combinational divide/modulo, removing the `/` and `%` logic from the renderer's pixel path.
- valid/ready handshake on both sides; one conversion in flight at a time.

---
 rtl/bcd_digit_extractor_if.sv | 30 +++
 rtl/bcd_digit_extractor.sv | 138 +++++++++++++
 tb/tb_bcd_digit_extractor.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_digit_extractor_if.sv
// Handshake bundle between the result source, the BCD extractor and the
// VGA digit renderer. The extractor attaches through the slave modport;
// whoever drives it (the upstream source plus the downstream consumer)
// uses the master modport.
interface bcd_digit_extractor_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  // Upstream: binary value to convert
  logic                          in_valid;
  logic                          in_ready;
  logic [WIDTH-1:0]              in_value;
  // Downstream: converted digits
  logic                          out_valid;
  logic                          out_ready;
  logic [4*DIGITS-1:0]           bcd_digits;
  logic [$clog2(DIGITS+1)-1:0]   num_digits;
  logic                          neg;
  logic                          busy;

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, bcd_digits, num_digits, neg, busy
  );

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, bcd_digits, num_digits, neg, busy
  );
endinterface

// File: rtl/bcd_digit_extractor.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble) feeding
// the VGA digit renderer. It accepts one value at a time in IDLE, runs WIDTH
// shift iterations, then holds the digits, the leading-zero-suppressed digit
// count and the sign flag in DONE until the consumer takes them.
// Optional feature: define BCD_SIGNED_EN to treat in_value as two's
// complement (magnitude converted, sign reported on neg). Without it the
// input is unsigned and neg stays 0.
module bcd_digit_extractor #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  bcd_digit_extractor_if.slave    bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int NW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;        // binary bits still to be shifted in
  logic [BW-1:0]     work_q, work_d;      // BCD digits being built
  logic [CW-1:0]     cnt_q, cnt_d;        // iterations remaining
  logic [BW-1:0]     digits_q, digits_d;  // held result
  logic [NW-1:0]     num_q, num_d;
  logic              sign_q, sign_d;      // sign of the value in flight
  logic              neg_q, neg_d;        // sign of the held result

  logic              in_sign;
  logic [WIDTH-1:0]  magnitude;
  logic [BW-1:0]     corrected;
  logic [BW+WIDTH-1:0] shifted;

`ifdef BCD_SIGNED_EN
  // Two's complement input: convert |in_value|; the most negative code
  // negates to itself, which read as unsigned is the correct magnitude.
  assign in_sign   = bus.in_value[WIDTH-1];
  assign magnitude = in_sign ? -bus.in_value : bus.in_value;
`else
  assign in_sign   = 1'b0;
  assign magnitude = bus.in_value;
`endif

  // Number of significant digits: position of the top nonzero nibble, min 1.
  function automatic logic [NW-1:0] count_digits(input logic [BW-1:0] d);
    logic [NW-1:0] n;
    n = NW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] != 4'd0) n = NW'(i + 1);
    end
    return n;
  endfunction

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift.
  always_comb begin
    corrected = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) corrected[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
    shifted = {corrected, bin_q} << 1;
  end

  // Next-state and datapath load decisions for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    bin_d    = bin_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    num_d    = num_q;
    sign_d   = sign_q;
    neg_d    = neg_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          bin_d   = magnitude;
          work_d  = '0;
          cnt_d   = CW'(WIDTH);
          sign_d  = in_sign;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted[BW+WIDTH-1:WIDTH];
        bin_d  = shifted[WIDTH-1:0];
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Last iteration: publish the result as DONE is entered.
          digits_d = shifted[BW+WIDTH-1:WIDTH];
          num_d    = count_digits(shifted[BW+WIDTH-1:WIDTH]);
          neg_d    = sign_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset that aborts any
  // conversion in flight.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      num_q    <= NW'(1);
      sign_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      num_q    <= num_d;
      sign_q   <= sign_d;
      neg_q    <= neg_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.busy       = (state_q == SHIFT);
  assign bus.bcd_digits = digits_q;
  assign bus.num_digits = num_q;
  assign bus.neg        = neg_q;
endmodule

// File: tb/tb_bcd_digit_extractor.sv
// Self-checking bench for bcd_digit_extractor. Expected digits come from
// decimal arithmetic on the input value (divide/modulo), not from any
// shift-add sequence. Define BCD_SIGNED_EN for both bench and RTL to cover
// the signed build.
module tb_bcd_digit_extractor;
  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  bcd_digit_extractor_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  bcd_digit_extractor #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Reference: {bcd_digits, num_digits, neg} from decimal arithmetic.
  function automatic logic [14:0] model(input logic [7:0] v);
    int          m;
    int          n;
    logic        ng;
    logic [11:0] d;
`ifdef BCD_SIGNED_EN
    ng = v[7];
    m  = ng ? 256 - int'(v) : int'(v);
`else
    ng = 1'b0;
    m  = int'(v);
`endif
    d = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    n = (m >= 100) ? 3 : ((m >= 10) ? 2 : 1);
    return {d, 2'(n), ng};
  endfunction

  function automatic logic [14:0] observed();
    return {bus.bcd_digits, bus.num_digits, bus.neg};
  endfunction

  // Present a value in IDLE; returns just after the accepting edge.
  task automatic start(input logic [7:0] v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = v;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid (bounded); also count busy cycles and note
  // any in_ready seen before the result.
  task automatic wait_result(output int lat, output int busy_cnt, output bit rdy_seen);
    lat      = 0;
    busy_cnt = bus.busy ? 1 : 0;
    rdy_seen = bus.in_ready;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.out_valid) begin
        if (bus.busy) busy_cnt++;
        if (bus.in_ready) rdy_seen = 1'b1;
      end
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_value = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100)
      $display("FAIL reset_flags: got rdy/vld/busy=%b expected 100", {bus.in_ready, bus.out_valid, bus.busy});
    else passed++;
    total++;
    if (observed() !== {12'h000, 2'd1, 1'b0})
      $display("FAIL reset_outputs: got %h expected %h", observed(), {12'h000, 2'd1, 1'b0});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat, bc; bit rs;
    start(8'd0);
    wait_result(lat, bc, rs);
    total++;
    if (lat !== 8) $display("FAIL zero_latency: got %0d expected 8", lat);
    else passed++;
    total++;
    if (observed() !== model(8'd0)) $display("FAIL zero_result: got %h expected %h", observed(), model(8'd0));
    else passed++;
    release_result();
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10)
      $display("FAIL zero_release: got rdy/vld=%b expected 10", {bus.in_ready, bus.out_valid});
    else passed++;
  endtask

  task automatic test_max();
    int lat, bc; bit rs;
    start(8'd255);
    wait_result(lat, bc, rs);
    total++;
    if (lat !== 8) $display("FAIL max_latency: got %0d expected 8", lat);
    else passed++;
    total++;
    if (bc !== 8) $display("FAIL max_busy_cycles: got %0d expected 8", bc);
    else passed++;
    total++;
    if (observed() !== model(8'd255)) $display("FAIL max_result: got %h expected %h", observed(), model(8'd255));
    else passed++;
    total++;
    if ({bus.in_ready, bus.busy} !== 2'b00)
      $display("FAIL max_done_flags: got rdy/busy=%b expected 00", {bus.in_ready, bus.busy});
    else passed++;
    release_result();
  endtask

  task automatic test_sequence();
    int lat, bc; bit rs;
    logic [7:0] vals [2];
    vals[0] = 8'd47;
    vals[1] = 8'd9;
    for (int i = 0; i < 2; i++) begin
      start(vals[i]);
      wait_result(lat, bc, rs);
      total++;
      if (rs !== 1'b0) $display("FAIL seq_in_ready_%0d: in_ready seen high=%b expected 0", i, rs);
      else passed++;
      total++;
      if (observed() !== model(vals[i]))
        $display("FAIL seq_result_%0d: got %h expected %h", i, observed(), model(vals[i]));
      else passed++;
      release_result();
      total++;
      if (observed() !== model(vals[i]))
        $display("FAIL seq_retained_%0d: got %h expected %h", i, observed(), model(vals[i]));
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    int lat, bc; bit rs;
    int bad;
    start(8'd123);
    wait_result(lat, bc, rs);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = 8'd99;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (observed() !== model(8'd123) || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
    else passed++;
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10 || observed() !== model(8'd123))
      $display("FAIL bp_release: got rdy/vld=%b out=%h expected 10 out=%h",
               {bus.in_ready, bus.out_valid}, observed(), model(8'd123));
    else passed++;
    @(posedge clk); #1;   // in_valid still held: 99 accepted here
    bus.in_valid = 1'b0;
    wait_result(lat, bc, rs);
    total++;
    if (lat !== 8 || observed() !== model(8'd99))
      $display("FAIL bp_second: got lat=%0d out=%h expected lat=8 out=%h", lat, observed(), model(8'd99));
    else passed++;
    release_result();
  endtask

  task automatic test_reset_abort();
    int spurious;
    start(8'd200);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100 || observed() !== {12'h000, 2'd1, 1'b0})
      $display("FAIL abort_state: got rdy/vld/busy=%b out=%h expected 100 out=%h",
               {bus.in_ready, bus.out_valid, bus.busy}, observed(), {12'h000, 2'd1, 1'b0});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) spurious++;
    end
    total++;
    if (spurious !== 0) $display("FAIL abort_quiet: got %0d bad cycles expected 0", spurious);
    else passed++;
  endtask

  task automatic test_random();
    int lat, bc; bit rs;
    logic [7:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom_range(0, 255));
      start(v);
      wait_result(lat, bc, rs);
      total++;
      if (lat !== 8 || observed() !== model(v))
        $display("FAIL rand_%0d: value %0d got lat=%0d out=%h expected lat=8 out=%h",
                 i, v, lat, observed(), model(v));
      else passed++;
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    int n_edge, first, second;
    logic prev;
    logic [7:0] v;
    v = 8'd186;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_value = v;
    bus.out_ready = 1'b1;
    n_edge = 0; first = -1; second = -1; prev = 1'b0;
    while (second < 0 && n_edge < 60) begin
      @(posedge clk); #1;
      n_edge++;
      if (bus.out_valid && !prev) begin
        if (first < 0) first = n_edge;
        else second = n_edge;
      end
      prev = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    total++;
    if (second - first !== 10)
      $display("FAIL b2b_period: got %0d expected 10", second - first);
    else passed++;
    total++;
    if (observed() !== model(v)) $display("FAIL b2b_result: got %h expected %h", observed(), model(v));
    else passed++;
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef BCD_SIGNED_EN
  task automatic test_signed();
    int lat, bc; bit rs;
    logic [7:0] vals [3];
    vals[0] = 8'h80;
    vals[1] = 8'hF6;
    vals[2] = 8'h05;
    for (int i = 0; i < 3; i++) begin
      start(vals[i]);
      wait_result(lat, bc, rs);
      total++;
      if (lat !== 8 || observed() !== model(vals[i]))
        $display("FAIL signed_%0d: value %h got lat=%0d out=%h expected lat=8 out=%h",
                 i, vals[i], lat, observed(), model(vals[i]));
      else passed++;
      release_result();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_sequence();
    test_backpressure();
    test_reset_abort();
    test_random();
    test_back_to_back();
`ifdef BCD_SIGNED_EN
    test_signed();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
